decode_ctrl_pipe: RTL and testbench

DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

---
 rtl/decode_ctrl_pipe.sv | 165 ++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// MIPS decode stage with a one-entry registered control-bundle buffer.
// Multiply/divide instructions are held for MDU_LAT cycles before being presented.
module decode_ctrl_pipe #(
    parameter int MDU_LAT = 4,
    parameter bit EN_MDU  = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        alu_src,
    output logic        link,
    output logic [4:0]  dst_reg,
    output logic [3:0]  alu_ctrl,
    output logic [2:0]  mdu_op,
    output logic        mdu_busy
);
    // state | meaning
    // EMPTY | no bundle held, ready to accept
    // FULL  | bundle presented on outputs, out_valid high
    // MDU   | mult/div bundle held while the latency counter runs down
    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_MDU} state_t;

    localparam logic [3:0] LAT_M1 = (MDU_LAT > 0) ? 4'(MDU_LAT - 1) : 4'd0;

    state_t     state;
    logic [3:0] cnt;
    logic       rdy_en;

    logic [5:0] op, funct;
    logic [4:0] rt, rd;
    assign op    = instr[31:26];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];

    logic unused_bits;
    assign unused_bits = ^{instr[25:21], instr[10:6]};

    logic       d_rw, d_mr, d_mw, d_as, d_lk;
    logic [4:0] d_dst;
    logic [3:0] d_alu;
    logic [2:0] d_mdu;

    always_comb begin
        d_rw  = 1'b0;
        d_mr  = 1'b0;
        d_mw  = 1'b0;
        d_as  = 1'b0;
        d_lk  = 1'b0;
        d_dst = rt;
        d_alu = 4'd0;
        d_mdu = 3'd0;
        case (op)
            6'h00: begin
                d_dst = rd;
                case (funct)
                    6'h00: begin d_rw = 1'b1; d_as = 1'b1; d_alu = 4'd8;  end
                    6'h02: begin d_rw = 1'b1; d_as = 1'b1; d_alu = 4'd9;  end
                    6'h03: begin d_rw = 1'b1; d_as = 1'b1; d_alu = 4'd10; end
                    6'h08: ;
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        if (EN_MDU) d_mdu = {1'b0, funct[1:0]} + 3'd1;
                        else        d_dst = 5'd0;
                    end
                    6'h21: begin d_rw = 1'b1; d_alu = 4'd0; end
                    6'h23: begin d_rw = 1'b1; d_alu = 4'd1; end
                    6'h24: begin d_rw = 1'b1; d_alu = 4'd2; end
                    6'h25: begin d_rw = 1'b1; d_alu = 4'd3; end
                    6'h26: begin d_rw = 1'b1; d_alu = 4'd4; end
                    6'h27: begin d_rw = 1'b1; d_alu = 4'd5; end
                    6'h2A: begin d_rw = 1'b1; d_alu = 4'd6; end
                    6'h2B: begin d_rw = 1'b1; d_alu = 4'd7; end
                    default: d_dst = 5'd0;
                endcase
            end
            6'h02: d_as = 1'b1;
            6'h03: begin d_rw = 1'b1; d_as = 1'b1; d_lk = 1'b1; d_dst = 5'd31; end
            6'h04, 6'h05: begin d_as = 1'b1; d_alu = 4'd1; end
            6'h09: begin d_rw = 1'b1; d_as = 1'b1; d_alu = 4'd0;  end
            6'h0A: begin d_rw = 1'b1; d_as = 1'b1; d_alu = 4'd6;  end
            6'h0B: begin d_rw = 1'b1; d_as = 1'b1; d_alu = 4'd7;  end
            6'h0C: begin d_rw = 1'b1; d_as = 1'b1; d_alu = 4'd2;  end
            6'h0D: begin d_rw = 1'b1; d_as = 1'b1; d_alu = 4'd3;  end
            6'h0E: begin d_rw = 1'b1; d_as = 1'b1; d_alu = 4'd4;  end
            6'h0F: begin d_rw = 1'b1; d_as = 1'b1; d_alu = 4'd11; end
            6'h23: begin d_rw = 1'b1; d_mr = 1'b1; d_as = 1'b1; end
            6'h2B: begin d_mw = 1'b1; d_as = 1'b1; end
            default: d_dst = 5'd0;
        endcase
    end

    logic accept, hold_mdu;
    assign in_ready = rdy_en && !flush &&
                      ((state == S_EMPTY) || ((state == S_FULL) && out_ready));
    assign accept   = in_valid && in_ready;
    assign hold_mdu = (d_mdu != 3'd0) && (MDU_LAT > 0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_EMPTY;
            cnt        <= 4'd0;
            rdy_en     <= 1'b0;
            out_valid  <= 1'b0;
            mdu_busy   <= 1'b0;
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            mem_write  <= 1'b0;
            alu_src    <= 1'b0;
            link       <= 1'b0;
            dst_reg    <= 5'd0;
            alu_ctrl   <= 4'd0;
            mdu_op     <= 3'd0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                state     <= S_EMPTY;
                cnt       <= 4'd0;
                out_valid <= 1'b0;
                mdu_busy  <= 1'b0;
            end else if (accept) begin
                reg_write  <= d_rw && (d_dst != 5'd0);
                mem_to_reg <= d_mr;
                mem_write  <= d_mw;
                alu_src    <= d_as;
                link       <= d_lk;
                dst_reg    <= d_dst;
                alu_ctrl   <= d_alu;
                mdu_op     <= d_mdu;
                if (hold_mdu) begin
                    state     <= S_MDU;
                    cnt       <= LAT_M1;
                    out_valid <= 1'b0;
                    mdu_busy  <= 1'b1;
                end else begin
                    state     <= S_FULL;
                    out_valid <= 1'b1;
                    mdu_busy  <= 1'b0;
                end
            end else begin
                case (state)
                    S_FULL: if (out_ready) begin
                        state     <= S_EMPTY;
                        out_valid <= 1'b0;
                    end
                    S_MDU: if (cnt == 4'd0) begin
                        state     <= S_FULL;
                        out_valid <= 1'b1;
                        mdu_busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: expected bundles are queued at issue
// and compared whenever the DUT hands a bundle to execute.
module tb_decode_ctrl_pipe;
    logic        clk = 1'b0;
    logic        resetn, in_valid, in_ready, flush, out_valid, out_ready;
    logic        reg_write, mem_to_reg, mem_write, alu_src, link, mdu_busy;
    logic [31:0] instr;
    logic [4:0]  dst_reg;
    logic [3:0]  alu_ctrl;
    logic [2:0]  mdu_op;

    int checks = 0;
    int fails  = 0;
    logic [16:0] sb[$];
    logic [16:0] mon_exp;
    logic [31:0] pat_w[8];
    logic [16:0] pat_e[8];

    decode_ctrl_pipe #(.MDU_LAT(4), .EN_MDU(1'b1)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
        .alu_src(alu_src), .link(link), .dst_reg(dst_reg), .alu_ctrl(alu_ctrl),
        .mdu_op(mdu_op), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    logic [16:0] bundle;
    assign bundle = {reg_write, mem_to_reg, mem_write, alu_src, link, dst_reg, alu_ctrl, mdu_op};

    function automatic logic [16:0] mk(int rw, int mr, int mw, int as_, int lk, int d, int a, int m);
        return {1'(rw), 1'(mr), 1'(mw), 1'(as_), 1'(lk), 5'(d), 4'(a), 3'(m)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one instruction and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic [31:0] w, input logic [16:0] exp, input bit push);
        int n;
        in_valid = 1'b1;
        instr    = w;
        if (push) sb.push_back(exp);
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk("accept_wait", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected: observed bundle %0h expected none", bundle);
            end
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                chk("sb_bundle", 32'(bundle), 32'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pat_w[0] = 32'h3C071234; pat_e[0] = mk(1,0,0,1,0,7,11,0);  // LUI $7
        pat_w[1] = 32'h000220C0; pat_e[1] = mk(1,0,0,1,0,4,8,0);   // SLL $4,$2,3
        pat_w[2] = 32'h00853023; pat_e[2] = mk(1,0,0,0,0,6,1,0);   // SUBU $6,$4,$5
        pat_w[3] = 32'h2C490007; pat_e[3] = mk(1,0,0,1,0,9,7,0);   // SLTIU $9,$2,7
        pat_w[4] = 32'hFC000000; pat_e[4] = mk(0,0,0,0,0,0,0,0);   // unknown opcode
        pat_w[5] = 32'h00225027; pat_e[5] = mk(1,0,0,0,0,10,5,0);  // NOR $10,$1,$2
        pat_w[6] = 32'h00220021; pat_e[6] = mk(0,0,0,0,0,0,0,0);   // ADDU $0: write suppressed
        pat_w[7] = 32'h0022582A; pat_e[7] = mk(1,0,0,0,0,11,6,0);  // SLT $11,$1,$2

        resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instr = 32'd0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mdu_busy", 32'(mdu_busy), 32'd0);
        chk("rst_bundle", 32'(bundle), 32'd0);
        resetn = 1'b1;
        tick();
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        send(32'h00221821, mk(1,0,0,0,0,3,0,0), 1'b1);
        chk("addu_latency", 32'(out_valid), 32'd1);
        chk("addu_dst", 32'(dst_reg), 32'd3);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        send(32'h24200005, mk(0,0,0,1,0,0,0,0), 1'b1);
        chk("addiu_r0_rw", 32'(reg_write), 32'd0);
        send(32'h0C000100, mk(1,0,0,1,1,31,0,0), 1'b1);
        chk("jal_b2b_valid", 32'(out_valid), 32'd1);
        chk("jal_link", 32'(link), 32'd1);
        for (int i = 0; i < 8; i++) send(pat_w[i], pat_e[i], 1'b1);
        tick();
        chk("pat_drain", 32'(out_valid), 32'd0);

        send(32'h00220018, mk(0,0,0,0,0,0,0,1), 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("mult_busy", 32'(mdu_busy), 32'd1);
            chk("mult_in_ready", 32'(in_ready), 32'd0);
            chk("mult_no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        chk("mult_valid", 32'(out_valid), 32'd1);
        chk("mult_busy_done", 32'(mdu_busy), 32'd0);
        chk("mult_op", 32'(mdu_op), 32'd1);
        tick();
        chk("mult_drain", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        send(32'h8C250008, mk(1,1,0,1,0,5,0,0), 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_bundle", 32'(bundle), 32'(mk(1,1,0,1,0,5,0,0)));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        send(32'hAC250008, mk(0,0,1,1,0,5,0,0), 1'b1);
        chk("replace_no_bubble", 32'(out_valid), 32'd1);
        chk("replace_mem_write", 32'(mem_write), 32'd1);
        tick();
        chk("replace_drain", 32'(out_valid), 32'd0);

        send(32'h00220018, 17'd0, 1'b0);
        tick();
        flush = 1'b1;
        #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_busy", 32'(mdu_busy), 32'd0);
        #1 chk("flush_empty_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("flush_no_valid", 32'(out_valid), 32'd0);
            tick();
        end

        out_ready = 1'b0;
        send(32'h340800FF, 17'd0, 1'b0);
        chk("ori_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1; instr = 32'h38090001; flush = 1'b1;
        #1 chk("flush_dom_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_dom_empty", 32'(out_valid), 32'd0);
        tick();
        chk("flush_dom_no_accept", 32'(out_valid), 32'd0);

        send(32'h00221821, 17'd0, 1'b0);
        chk("pre_reset_full", 32'(out_valid), 32'd1);
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_bundle", 32'(bundle), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        #1 chk("rerst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
